// File: rtl/wb_queue.sv
// Register-file write-back queue: DEPTH-entry FIFO of {rd, data} with youngest-match bypass.
// Accept-to-W_en latency >= 1 cycle; in_ready = !full (ignores same-cycle drain), wb_hold stalls the drain.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_rd,
  input  logic [31:0]                in_data,
  input  logic                       wb_hold,
  output logic                       W_en,
  output logic [4:0]                 Rd,
  output logic [31:0]                Wr_data,
  input  logic [4:0]                 Rs1,
  input  logic [4:0]                 Rs2,
  output logic                       fwd1_hit,
  output logic                       fwd2_hit,
  output logic [31:0]                fwd1_data,
  output logic [31:0]                fwd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [PW-1:0] scan_idx;

  assign count    = cnt;
  assign empty    = (cnt == '0);
  assign full     = (cnt == CW'(DEPTH));
  assign in_ready = !full;

  // Writes to r0 are accepted but never stored.
  assign push = in_valid && in_ready && (in_rd != 5'd0);
  assign pop  = W_en;

  assign W_en    = !empty && !wb_hold;
  assign Rd      = empty ? 5'd0  : rd_mem[head];
  assign Wr_data = empty ? 32'd0 : data_mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        rd_mem[tail]   <= in_rd;
        data_mem[tail] <= in_data;
        tail           <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      // Clear before set: head and tail coincide only when empty or full, and neither allows both.
      if (pop)  valid[head] <= 1'b0;
      if (push) valid[tail] <= 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    scan_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PW'(i);
      if (valid[scan_idx] && (Rs1 != 5'd0) && (rd_mem[scan_idx] == Rs1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_mem[scan_idx];
      end
      if (valid[scan_idx] && (Rs2 != 5'd0) && (rd_mem[scan_idx] == Rs2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_mem[scan_idx];
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4): hand-computed expectations, one check task.
module tb_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        wb_hold;
  logic        w_en;
  logic [4:0]  rd;
  logic [31:0] wr_data;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic        fwd2_hit;
  logic [31:0] fwd1_data;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_cmp = 0;
  int n_err = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_hold(wb_hold),
    .W_en(w_en), .Rd(rd), .Wr_data(wr_data),
    .Rs1(rs1), .Rs2(rs2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
    wb_hold = 1'b0; rs1 = '0; rs2 = '0;

    // Reset values, before any clock edge
    #2;
    check_val("rst_empty",    32'(empty),    32'd1);
    check_val("rst_full",     32'(full),     32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_wen",      32'(w_en),     32'd0);
    check_val("rst_count",    32'(count),    32'd0);
    check_val("rst_rd",       32'(rd),       32'd0);
    check_val("rst_wrdata",   wr_data,       32'd0);
    check_val("rst_fwd1",     32'(fwd1_hit), 32'd0);
    tick();
    #6 rst = 1'b0;
    tick();

    // Single push under hold, bypass, then drain
    wb_hold = 1'b1; in_valid = 1'b1; in_rd = 5'd5; in_data = 32'h11; rs1 = 5'd5;
    #1;
    check_val("t1_fwd_same_cycle", 32'(fwd1_hit), 32'd0);
    check_val("t1_wen_same_cycle", 32'(w_en),     32'd0);
    tick();
    in_valid = 1'b0;
    check_val("t1_count",    32'(count),    32'd1);
    check_val("t1_wen_hold", 32'(w_en),     32'd0);
    check_val("t1_fwd_hit",  32'(fwd1_hit), 32'd1);
    check_val("t1_fwd_data", fwd1_data,     32'h11);
    wb_hold = 1'b0;
    #1;
    check_val("t1_wen",      32'(w_en),     32'd1);
    check_val("t1_rd",       32'(rd),       32'd5);
    check_val("t1_wrdata",   wr_data,       32'h11);
    check_val("t1_fwd_drain",32'(fwd1_hit), 32'd1);
    tick();
    check_val("t1_empty",    32'(empty),    32'd1);
    check_val("t1_wen_off",  32'(w_en),     32'd0);

    // Fill to full under hold, refuse 5th, drain in order
    wb_hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_data = 32'h100 + i;
      tick();
    end
    in_rd = 5'd9; in_data = 32'h999;
    #1;
    check_val("t2_full",     32'(full),     32'd1);
    check_val("t2_in_ready", 32'(in_ready), 32'd0);
    check_val("t2_count4",   32'(count),    32'd4);
    tick();
    in_valid = 1'b0; rs1 = 5'd9;
    #1;
    check_val("t2_count_after_5th", 32'(count),    32'd4);
    check_val("t2_5th_not_stored",  32'(fwd1_hit), 32'd0);
    wb_hold = 1'b0;
    #1;
    check_val("t2_ready_while_drain", 32'(in_ready), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      check_val("t2_wen",    32'(w_en), 32'd1);
      check_val("t2_rd",     32'(rd),   32'(i));
      check_val("t2_wrdata", wr_data,   32'h100 + i);
      tick();
    end
    check_val("t2_empty", 32'(empty), 32'd1);
    check_val("t2_wen_off", 32'(w_en), 32'd0);

    // Same rd twice: bypass picks youngest, both drain oldest first
    wb_hold = 1'b1; rs2 = 5'd7;
    in_valid = 1'b1; in_rd = 5'd7; in_data = 32'hA;
    tick();
    check_val("t3_fwd_first", fwd2_data, 32'hA);
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    check_val("t3_fwd_hit",   32'(fwd2_hit), 32'd1);
    check_val("t3_fwd_young", fwd2_data,     32'hB);
    wb_hold = 1'b0;
    #1;
    check_val("t3_first_data", wr_data, 32'hA);
    tick();
    check_val("t3_second_wen",  32'(w_en), 32'd1);
    check_val("t3_second_data", wr_data,   32'hB);
    tick();
    check_val("t3_empty",  32'(empty),    32'd1);
    check_val("t3_no_fwd", 32'(fwd2_hit), 32'd0);

    // Write to r0 is discarded
    rs1 = 5'd0; in_valid = 1'b1; in_rd = 5'd0; in_data = 32'hFF;
    #1;
    check_val("t4_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("t4_count", 32'(count),    32'd0);
    check_val("t4_wen",   32'(w_en),     32'd0);
    check_val("t4_fwd0",  32'(fwd1_hit), 32'd0);
    tick();
    check_val("t4_wen_later", 32'(w_en), 32'd0);

    // Streaming push/pop across pointer wrap
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_rd = 5'((i % 31) + 1); in_data = 32'h2000 + i;
      #1;
      if (i > 0) begin
        check_val("t5_count",  32'(count), 32'd1);
        check_val("t5_wen",    32'(w_en),  32'd1);
        check_val("t5_rd",     32'(rd),    32'(((i - 1) % 31) + 1));
        check_val("t5_wrdata", wr_data,    32'h2000 + i - 1);
      end
      tick();
    end
    in_valid = 1'b0;
    check_val("t5_last", wr_data, 32'h2000 + 19);
    tick();
    check_val("t5_empty", 32'(empty), 32'd1);

    // Reset mid-cycle with three pending entries
    wb_hold = 1'b1; rs1 = 5'd11;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 32'hC0 + i;
      tick();
    end
    in_valid = 1'b0;
    check_val("t6_count3", 32'(count),    32'd3);
    check_val("t6_fwd",    32'(fwd1_hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("t6_count0",   32'(count),    32'd0);
    check_val("t6_empty",    32'(empty),    32'd1);
    check_val("t6_wen",      32'(w_en),     32'd0);
    check_val("t6_rd",       32'(rd),       32'd0);
    check_val("t6_wrdata",   wr_data,       32'd0);
    check_val("t6_fwd_clr",  32'(fwd1_hit), 32'd0);
    check_val("t6_fwd_data", fwd1_data,     32'd0);
    wb_hold = 1'b0;
    tick();
    check_val("t6_wen_in_rst", 32'(w_en), 32'd0);
    #3 rst = 1'b0;
    tick();
    check_val("t6_wen_after_rst", 32'(w_en),  32'd0);
    check_val("t6_empty_after",   32'(empty), 32'd1);
    in_valid = 1'b1; in_rd = 5'd6; in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    check_val("t6_new_wen",    32'(w_en), 32'd1);
    check_val("t6_new_rd",     32'(rd),   32'd6);
    check_val("t6_new_wrdata", wr_data,   32'h66);
    tick();
    check_val("t6_final_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 DEPTH, 4, number of buffered register-write entries; power of two, 2 to 16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  producer presents a register-write request.
REQ-005 in_ready  output  1  queue can accept a request this cycle.
REQ-006 in_rd  input  5  destination register address of the request.
REQ-007 in_data  input  32  write data of the request.
REQ-008 wb_hold  input  1  register-file write port unavailable this cycle; no drain.
REQ-009 W_en  output  1  register-file write enable.
REQ-010 Rd  output  5  register-file write address.
REQ-011 Wr_data  output  32  register-file write data.
REQ-012 Rs1, Rs2  input  5 each  source-register addresses for bypass lookup.
REQ-013 fwd1_hit, fwd2_hit  output  1 each  a pending entry matches Rs1 / Rs2.
REQ-014 fwd1_data, fwd2_data  output  32 each  data of the matching pending entry.
REQ-015 count  output  clog2(DEPTH)+1  number of valid entries.
REQ-016 empty, full  output  1 each  count==0 / count==DEPTH.

Function
REQ-017 Storage: circular FIFO of DEPTH entries {rd[4:0], data[31:0]}; head and tail pointers wrap modulo DEPTH.
REQ-018 in_ready = !full, combinational; in_ready does not depend on same-cycle drain.
REQ-019 Accept = in_valid && in_ready; an accepted request with in_rd!=0 is written at tail at the clock edge, tail advances.
REQ-020 An accepted request with in_rd==0 is consumed and discarded: no entry, no count change, never appears on W_en.
REQ-021 W_en = !empty && !wb_hold; Rd and Wr_data always show the head entry (zero when empty); drive combinationally from stored state only.
REQ-022 When W_en is 1, the head entry is popped at the clock edge and head advances; latency from accept to W_en is at least 1 cycle.
REQ-023 Entries drain strictly in acceptance order; one entry per cycle maximum.
REQ-024 Simultaneous push and pop: both pointers advance, count unchanged.
REQ-025 Push ignored when full (in_ready=0); pop ignored when empty (W_en=0); count never exceeds DEPTH or underflows.
REQ-026 Bypass: fwdN_hit = 1 when RsN!=0 and any valid entry (including head) has rd==RsN; fwdN_data = data of the youngest such entry; else fwdN_hit=0, fwdN_data=0.
REQ-027 Bypass is combinational from stored state; a request accepted in the current cycle is not visible to bypass until the next cycle.
REQ-028 Head entry being drained this cycle remains a bypass candidate this cycle.
REQ-029 Multiple pending writes to the same rd are all kept and all drained; only bypass selects the youngest.

Reset
REQ-030 rst asserted: immediately, regardless of clk, head=tail=0, count=0, all entry valid state cleared; empty=1, full=0, in_ready=1, W_en=0, Rd=0, Wr_data=0, fwd hits 0, fwd data 0.
REQ-031 Reset mid-operation discards all pending entries without issuing W_en; first accept after rst deassert is handled normally on the next rising edge.

Verification
REQ-032 Push rd=5,data=0x11 with wb_hold=1 -> next cycle count=1, W_en=0, Rs1=5 gives fwd1_hit=1, fwd1_data=0x11; release wb_hold -> W_en=1,Rd=5,Wr_data=0x11 one cycle, then empty=1.
REQ-033 wb_hold=1, push 4 requests rd=1..4 -> full=1, in_ready=0, 5th request with in_valid=1 not accepted; release hold -> W_en on 4 consecutive cycles, Rd=1,2,3,4 in order.
REQ-034 Push rd=7 data=0xA then rd=7 data=0xB with hold -> Rs2=7 gives fwd2_data=0xB; drain -> both writes issued, 0xA first.
REQ-035 Push rd=0 data=0xFF -> count stays 0, W_en never asserts; Rs1=0 -> fwd1_hit=0.
REQ-036 Steady push every cycle with wb_hold=0 -> count holds at 1, one W_en per cycle, pointers wrap past DEPTH without loss or reorder over 20 pushes.
REQ-037 3 entries pending, assert rst between clock edges -> outputs reach reset values before next edge; no W_en for discarded entries.
